// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution control blocks: the filter-load
// sequencer state encoding and the default filter length.
`ifndef WID_FILTER
`define WID_FILTER 8
`endif

package conv_ctrl_pkg;

    // Filter-load sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_CONV = 2'd2,
        ST_FINISH    = 2'd3
    } conv_state_e;

    // Taps per filter shift register (3x3 kernel).
    localparam int TAPS_DEFAULT = 9;

endpackage

// File: rtl/filter_load_ctrl.sv
// Filter load controller: streams weight beats into NUM_SR external filter
// shift registers, TAPS beats per register, starting at register 0.
//
// Handshake: a weight beat transfers on a rising clk edge where w_valid and
// w_ready are both high; the source holds w_data stable while w_valid is high
// and w_ready is low. w_ready is only offered in LOAD while the convolver is
// idle (conv_active low), so weights never change under an active convolution.
//
// Each accepted beat is re-driven one cycle later on sr_data together with a
// single-cycle one-hot sr_shift bit for the register being filled. The
// loaded[] flag of a register rises together with its final (TAPS-th) pulse.
`ifndef WID_FILTER
`define WID_FILTER 8
`endif

module filter_load_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int NUM_SR = 4,
    parameter int TAPS   = TAPS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(NUM_SR+1)-1:0]   num_sr,
    input  logic                          conv_active,
    input  logic [`WID_FILTER-1:0]        w_data,
    input  logic                          w_valid,
    output logic                          w_ready,
    output logic [`WID_FILTER-1:0]        sr_data,
    output logic [NUM_SR-1:0]             sr_shift,
    output logic [NUM_SR-1:0]             loaded,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int CNT_W = $clog2(NUM_SR + 1);
    localparam int IDX_W = (NUM_SR > 1) ? $clog2(NUM_SR) : 1;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    // Registered state
    conv_state_e              state;
    logic [TAP_W-1:0]         tap_cnt;
    logic [IDX_W-1:0]         sr_idx;
    logic [CNT_W-1:0]         job_len;

    // Next-state values
    conv_state_e              state_next;
    logic [TAP_W-1:0]         tap_next;
    logic [IDX_W-1:0]         idx_next;
    logic [CNT_W-1:0]         len_next;
    logic [NUM_SR-1:0]        loaded_next;
    logic [NUM_SR-1:0]        shift_next;
    logic [`WID_FILTER-1:0]   data_next;
    logic                     done_next;
    logic                     err_next;

    // Decoded conditions
    logic                     accept;
    logic                     start_ok;
    logic                     last_tap;
    logic                     last_sr;
    logic [NUM_SR-1:0]        sel_onehot;

    // Beats are only taken while loading and the convolver is idle.
    assign w_ready    = (state == ST_LOAD) && !conv_active;
    assign accept     = w_valid && w_ready;
    assign busy       = (state != ST_IDLE);

    // Job sizes outside 1..NUM_SR are rejected with an err pulse.
    assign start_ok   = (num_sr != '0) && (num_sr <= CNT_W'(NUM_SR));

    assign last_tap   = (tap_cnt == TAP_W'(TAPS - 1));
    assign last_sr    = ((CNT_W'(sr_idx) + CNT_W'(1)) == job_len);
    assign sel_onehot = {{(NUM_SR-1){1'b0}}, 1'b1} << sr_idx;

    // Next-state and registered-output decode for the load sequencer.
    always_comb begin
        state_next  = state;
        tap_next    = tap_cnt;
        idx_next    = sr_idx;
        len_next    = job_len;
        loaded_next = loaded;
        shift_next  = '0;
        data_next   = sr_data;
        done_next   = 1'b0;
        err_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_next  = conv_active ? ST_WAIT_CONV : ST_LOAD;
                        tap_next    = '0;
                        idx_next    = '0;
                        len_next    = num_sr;
                        loaded_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            ST_WAIT_CONV: begin
                if (!conv_active) begin
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // A rising conv_active parks the job; counters are kept so
                // the load resumes at the same tap.
                if (conv_active) begin
                    state_next = ST_WAIT_CONV;
                end else if (accept) begin
                    shift_next = sel_onehot;
                    data_next  = w_data;
                    if (last_tap) begin
                        tap_next    = '0;
                        loaded_next = loaded | sel_onehot;
                        if (last_sr) begin
                            state_next = ST_FINISH;
                            done_next  = 1'b1;
                        end else begin
                            idx_next = sr_idx + 1'b1;
                        end
                    end else begin
                        tap_next = tap_cnt + 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                // Final shift pulse and done are on the outputs this cycle.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides any beat or start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tap_cnt  <= '0;
            sr_idx   <= '0;
            job_len  <= '0;
            loaded   <= '0;
            sr_shift <= '0;
            sr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            tap_cnt  <= tap_next;
            sr_idx   <= idx_next;
            job_len  <= len_next;
            loaded   <= loaded_next;
            sr_shift <= shift_next;
            sr_data  <= data_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Directed bench for filter_load_ctrl. A negedge monitor logs every shift
// pulse as {cycle, sr_shift, sr_data}; each scenario builds its own expected
// pulse list and compares it, plus spot checks of the flags.
`ifndef WID_FILTER
`define WID_FILTER 8
`endif

module tb_filter_load_ctrl;

    localparam int NUM_SR = 4;
    localparam int TAPS   = 9;
    localparam int CNT_W  = $clog2(NUM_SR + 1);
    localparam int WID    = `WID_FILTER;
    localparam int EW     = 16 + NUM_SR + WID;

    // Clock / reset and DUT signals
    logic                clk;
    logic                rst;
    logic                start;
    logic [CNT_W-1:0]    num_sr;
    logic                conv_active;
    logic [WID-1:0]      w_data;
    logic                w_valid;
    logic                w_ready;
    logic [WID-1:0]      sr_data;
    logic [NUM_SR-1:0]   sr_shift;
    logic [NUM_SR-1:0]   loaded;
    logic                busy;
    logic                done;
    logic                err;

    // Scoreboard
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    int checks    = 0;
    int fails     = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int multi_hot = 0;
    int stalls    = 0;

    filter_load_ctrl #(
        .NUM_SR (NUM_SR),
        .TAPS   (TAPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_sr      (num_sr),
        .conv_active (conv_active),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .sr_data     (sr_data),
        .sr_shift    (sr_shift),
        .loaded      (loaded),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse / flag monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (sr_shift != '0) obs_q.push_back({cyc[15:0], sr_shift, sr_data});
        if ($countones(sr_shift) > 1) multi_hot <= multi_hot + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (always entered and left at a negedge)
    task automatic do_start(input int n, input logic conv);
        start       = 1'b1;
        num_sr      = CNT_W'(n);
        conv_active = conv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one beat, wait (bounded) for acceptance, record the expected pulse.
    task automatic send_beat(input logic [WID-1:0] d, input int idx);
        int waited;
        logic [NUM_SR-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        waited = 0;
        w_data  = d;
        w_valid = 1'b1;
        #1;
        while (!w_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!w_ready) begin
            fails++;
            $display("FAIL beat_accept: w_ready=0 after %0d cycles for data %h, required 1", waited, d);
        end else begin
            exp_q.push_back({16'(cyc + 1), oh, d});
            stalls += waited;
        end
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        checks++; if (sr_shift !== 4'b0000) begin fails++; $display("FAIL rst_sr_shift: got %b required 0000", sr_shift); end
        checks++; if (sr_data !== '0) begin fails++; $display("FAIL rst_sr_data: got %h required 0", sr_data); end
        checks++; if (loaded !== 4'b0000) begin fails++; $display("FAIL rst_loaded: got %b required 0000", loaded); end
        checks++; if (w_ready !== 1'b0) begin fails++; $display("FAIL rst_w_ready: got %b required 0", w_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", done); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b required 0", err); end
        // start while reset is held must not launch a job
        start  = 1'b1;
        num_sr = 3'd1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_over_start: busy=%b required 0", busy); end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int d0;
        exp_q.delete(); obs_q.delete(); stalls = 0; d0 = done_cnt;
        do_start(1, 1'b0);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b required 1", busy); end
        for (int k = 1; k <= 9; k++) begin
            send_beat(WID'(k), 0);
            if (k == 5) begin
                checks++; if (loaded !== 4'b0000) begin fails++; $display("FAIL single_loaded_mid: got %b required 0000", loaded); end
            end
        end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL single_done: got %b required 1", done); end
        checks++; if (w_ready !== 1'b0) begin fails++; $display("FAIL single_ready_finish: got %b required 0", w_ready); end
        checks++; if (loaded !== 4'b0001) begin fails++; $display("FAIL single_loaded: got %b required 0001", loaded); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_width: got %b required 0", done); end
        checks++; if (stalls !== 0) begin fails++; $display("FAIL single_stalls: got %0d required 0", stalls); end
        checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL single_done_count: got %0d required 1", done_cnt - d0); end
        checks++; if (obs_q.size() !== 9) begin fails++; $display("FAIL single_pulse_count: got %0d required 9", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_pulse[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_gaps();
        int d0, m0;
        exp_q.delete(); obs_q.delete(); stalls = 0; d0 = done_cnt; m0 = multi_hot;
        do_start(4, 1'b0);
        for (int k = 0; k < 36; k++) begin
            send_beat(WID'(16 + k), k / 9);
            if (k < 35) @(negedge clk);
        end
        checks++; if (loaded !== 4'b1111) begin fails++; $display("FAIL gaps_loaded: got %b required 1111", loaded); end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL gaps_done: got %b required 1", done); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL gaps_busy_end: got %b required 0", busy); end
        checks++; if (multi_hot - m0 !== 0) begin fails++; $display("FAIL gaps_onehot: %0d multi-bit cycles, required 0", multi_hot - m0); end
        checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL gaps_done_count: got %0d required 1", done_cnt - d0); end
        checks++; if (obs_q.size() !== 36) begin fails++; $display("FAIL gaps_pulse_count: got %0d required 36", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL gaps_pulse[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_err();
        int e0;
        obs_q.delete(); e0 = err_cnt;
        do_start(0, 1'b0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_zero: got %b required 1", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL err_zero_busy: got %b required 0", busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_zero_width: got %b required 0", err); end
        do_start(5, 1'b0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_big: got %b required 1", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL err_big_busy: got %b required 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL err_busy_after: got %b required 0", busy); end
        checks++; if (loaded !== 4'b1111) begin fails++; $display("FAIL err_loaded_kept: got %b required 1111", loaded); end
        checks++; if (err_cnt - e0 !== 2) begin fails++; $display("FAIL err_count: got %0d required 2", err_cnt - e0); end
        checks++; if (obs_q.size() !== 0) begin fails++; $display("FAIL err_no_pulse: got %0d pulses required 0", obs_q.size()); end
    endtask

    task automatic test_conv();
        int d0;
        exp_q.delete(); obs_q.delete(); d0 = done_cnt;
        do_start(1, 1'b1);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL conv_busy: got %b required 1", busy); end
        w_valid = 1'b1;
        w_data  = 8'hA0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (w_ready !== 1'b0) begin fails++; $display("FAIL conv_hold_ready[%0d]: got %b required 0", i, w_ready); end
            @(negedge clk);
        end
        conv_active = 1'b0;
        w_valid     = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (w_ready !== 1'b1) begin fails++; $display("FAIL conv_release_ready: got %b required 1", w_ready); end
        checks++; if (obs_q.size() !== 0) begin fails++; $display("FAIL conv_no_early_pulse: got %0d required 0", obs_q.size()); end
        @(negedge clk);
        for (int k = 1; k <= 4; k++) send_beat(WID'(8'h30 + k), 0);
        // convolver grabs the filters mid-load
        conv_active = 1'b1;
        w_valid     = 1'b1;
        w_data      = 8'hEE;
        #1;
        checks++; if (w_ready !== 1'b0) begin fails++; $display("FAIL conv_pause_ready: got %b required 0", w_ready); end
        @(negedge clk);
        conv_active = 1'b0;
        w_valid     = 1'b0;
        @(negedge clk);
        for (int k = 5; k <= 9; k++) begin
            send_beat(WID'(8'h30 + k), 0);
            if (k == 8) begin
                checks++; if (loaded !== 4'b0000) begin fails++; $display("FAIL conv_loaded_mid: got %b required 0000", loaded); end
            end
        end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL conv_done: got %b required 1", done); end
        checks++; if (loaded !== 4'b0001) begin fails++; $display("FAIL conv_loaded: got %b required 0001", loaded); end
        @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL conv_done_count: got %0d required 1", done_cnt - d0); end
        checks++; if (obs_q.size() !== 9) begin fails++; $display("FAIL conv_pulse_count: got %0d required 9", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL conv_pulse[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        exp_q.delete(); obs_q.delete(); d0 = done_cnt;
        do_start(2, 1'b0);
        for (int k = 1; k <= 13; k++) send_beat(WID'(8'h40 + k), (k <= 9) ? 0 : 1);
        checks++; if (loaded !== 4'b0001) begin fails++; $display("FAIL rmid_loaded_before: got %b required 0001", loaded); end
        // reset lands on the same edge as an acceptable beat
        rst     = 1'b1;
        w_valid = 1'b1;
        w_data  = 8'h77;
        @(negedge clk);
        checks++; if (sr_shift !== 4'b0000) begin fails++; $display("FAIL rmid_sr_shift: got %b required 0000", sr_shift); end
        checks++; if (sr_data !== '0) begin fails++; $display("FAIL rmid_sr_data: got %h required 0", sr_data); end
        checks++; if (loaded !== 4'b0000) begin fails++; $display("FAIL rmid_loaded: got %b required 0000", loaded); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b required 0", busy); end
        checks++; if (w_ready !== 1'b0) begin fails++; $display("FAIL rmid_w_ready: got %b required 0", w_ready); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL rmid_done: got %b required 0", done); end
        rst     = 1'b0;
        w_valid = 1'b0;
        @(negedge clk);
        checks++; if (sr_shift !== 4'b0000) begin fails++; $display("FAIL rmid_post_shift: got %b required 0000", sr_shift); end
        checks++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL rmid_no_done: got %0d required 0", done_cnt - d0); end
        checks++; if (obs_q.size() !== 13) begin fails++; $display("FAIL rmid_pulse_count: got %0d required 13", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_pulse[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        // a fresh job after the abandoned one
        exp_q.delete(); obs_q.delete(); d0 = done_cnt;
        do_start(1, 1'b0);
        for (int k = 1; k <= 9; k++) send_beat(WID'(8'h90 + k), 0);
        checks++; if (loaded !== 4'b0001) begin fails++; $display("FAIL rmid_new_loaded: got %b required 0001", loaded); end
        @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rmid_new_done: got %0d required 1", done_cnt - d0); end
        checks++; if (obs_q.size() !== 9) begin fails++; $display("FAIL rmid_new_count: got %0d required 9", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_new_pulse[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int d0, e0;
        exp_q.delete(); obs_q.delete(); d0 = done_cnt; e0 = err_cnt;
        do_start(2, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            if (k == 5) begin
                start  = 1'b1;
                num_sr = 3'd1;
            end
            send_beat(WID'(8'hC0 + k), (k - 1) / 9);
            start = 1'b0;
        end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b required 1", done); end
        checks++; if (loaded !== 4'b0011) begin fails++; $display("FAIL b2b_loaded: got %b required 0011", loaded); end
        // start in the completion cycle is also ignored
        start  = 1'b1;
        num_sr = 3'd1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_finish_start: busy=%b required 0", busy); end
        @(negedge clk);
        checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL b2b_no_err: got %0d required 0", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL b2b_done_count: got %0d required 1", done_cnt - d0); end
        checks++; if (obs_q.size() !== 18) begin fails++; $display("FAIL b2b_pulse_count: got %0d required 18", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_pulse[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence and report
    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_sr      = '0;
        conv_active = 1'b0;
        w_data      = '0;
        w_valid     = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_gaps();
        test_err();
        test_conv();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/filter_load_ctrl.md
FILTER_LOAD_CTRL -- requirements
Module: filter_load_ctrl

Interface
REQ-001 Parameter NUM_SR, default 4: number of 9-tap filter shift registers sequenced by this block.
REQ-002 Parameter TAPS, default 9: taps per shift register.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port start  input  1: one-cycle request to begin a load job.
REQ-006 Port num_sr  input  $clog2(NUM_SR+1): number of shift registers to load, starting at index 0; sampled with start.
REQ-007 Port conv_active  input  1: convolver is consuming filters; loads are blocked while it is high.
REQ-008 Port w_data  input  `WID_FILTER: weight stream data.
REQ-009 Port w_valid  input  1: weight stream valid.
REQ-010 Port w_ready  output  1: weight stream ready.
REQ-011 Port sr_data  output  `WID_FILTER: registered data to every shift register input.
REQ-012 Port sr_shift  output  NUM_SR: one-hot shift enables, one per shift register.
REQ-013 Port loaded  output  NUM_SR: per-register "holds a complete filter" flags.
REQ-014 Port busy  output  1: job in progress.
REQ-015 Port done  output  1: one-cycle pulse at job completion.
REQ-016 Port err  output  1: one-cycle pulse on a rejected start.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, WAIT_CONV and FINISH.
REQ-018 IDLE: start with num_sr in 1..NUM_SR -> LOAD if conv_active=0, else WAIT_CONV; tap_cnt=0, sr_idx=0, loaded cleared to 0, busy=1 from the next cycle.
REQ-019 IDLE: start with num_sr=0 or num_sr>NUM_SR -> err=1 for one cycle; state, counters and loaded unchanged.
REQ-020 WAIT_CONV: stay while conv_active=1, w_ready=0; move to LOAD on the first cycle conv_active=0.
REQ-021 LOAD: w_ready = ~conv_active; a beat is accepted when w_valid & w_ready.
REQ-022 LOAD: if conv_active rises, go to WAIT_CONV; tap_cnt and sr_idx are kept and no beat is accepted in that cycle.
REQ-023 Accepted beat: on the next cycle sr_data=w_data and sr_shift=one-hot(sr_idx), high for exactly one cycle (1-cycle latency); otherwise sr_shift=0 and sr_data holds its value.
REQ-024 tap_cnt increments per accepted beat; at TAPS-1 it wraps to 0, sr_idx increments, and loaded[sr_idx] is set in the same cycle its ninth shift pulse is driven.
REQ-025 Last accepted beat (sr_idx=num_sr-1, tap_cnt=TAPS-1) -> FINISH; w_ready=0 from the following cycle.
REQ-026 FINISH: last shift pulse drives, done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
REQ-027 start while busy=1 SHALL be ignored, with no err pulse.
REQ-028 Gaps in w_valid SHALL only stall the job; no timeout.
REQ-029 sr_shift SHALL never have more than one bit set in any cycle.
REQ-030 Total shift pulses per job SHALL be exactly TAPS*num_sr.

Reset
REQ-031 With rst=1 at a clock edge: state=IDLE, tap_cnt=0, sr_idx=0, sr_data=0, sr_shift=0, loaded=0, w_ready=0, busy=0, done=0, err=0.
REQ-032 Reset in mid-job SHALL abandon the job without a done pulse, and no shift pulse SHALL occur in the cycle after reset.
REQ-033 rst SHALL take priority over start and over any accepted beat in the same cycle.

Structure
REQ-034 Shared package conv_ctrl_pkg SHALL hold the FSM state enum typedef and the TAPS default constant; `WID_FILTER comes from the common header.
REQ-035 The design SHALL be a single module with no sub-module; the shift registers are instantiated outside it and driven through sr_data/sr_shift.

Verification
REQ-036 start, num_sr=1, 9 back-to-back beats 1..9 -> sr_shift=0001 on 9 consecutive cycles, each one cycle after its beat; loaded=0001; done pulses once; 9 shift pulses total.
REQ-037 num_sr=4, 36 beats with w_valid toggled every other cycle -> the shift pulse sequence is 9x bit0, 9x bit1, 9x bit2, 9x bit3; loaded=1111; never two bits high.
REQ-038 num_sr=0, then num_sr=5 (NUM_SR=4) -> err pulses twice; busy stays 0; loaded unchanged.
REQ-039 conv_active=1 at start, released after 5 cycles -> w_ready=0 for those 5 cycles; loading then proceeds normally; conv_active pulsed after beat 4 pauses the job and it resumes at tap 5.
REQ-040 rst asserted after 13 beats of a num_sr=2 job -> all outputs reach reset values next cycle, no done pulse; a new num_sr=1 job then completes correctly.
REQ-041 start pulsed during an active job -> ignored; the job completes with exactly TAPS*num_sr pulses.
